// File: rtl/video_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// video_ctrl_pkg
// Shared definitions for the multi-channel video bypass control:
//   - state_t        : write-master FSM states
//   - BYPASS_BIT     : bit position of the bypass flag inside avs_writedata
//   - MAX_CH/CH_IDX_W: upper channel bound and width of a channel index
//   - rr_pick()      : round-robin selection of the next pending channel
// ---------------------------------------------------------------------------
package video_ctrl_pkg;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam int BYPASS_BIT = 0;
    localparam int MAX_CH     = 16;
    localparam int CH_IDX_W   = 4;

    // Returns the first set bit of pending[num_ch-1:0] found when scanning
    // upward from last+1 and wrapping at num_ch. The caller only uses the
    // result when at least one pending bit is set.
    function automatic logic [CH_IDX_W-1:0] rr_pick(
        input logic [MAX_CH-1:0]   pending,
        input logic [CH_IDX_W-1:0] last,
        input int                  num_ch
    );
        logic [CH_IDX_W-1:0] pick;
        logic                found;
        int                  idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            idx = (int'(last) + k) % num_ch;
            if (!found && (k <= num_ch) && pending[idx[CH_IDX_W-1:0]]) begin
                pick  = idx[CH_IDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// One push-button channel: 2-FF synchronizer, stability counter, accepted
// level and a press pulse.
//   sys_clk  in  system clock
//   sys_rst  in  asynchronous active-high reset
//   key_n    in  raw active-low key, asynchronous to sys_clk
//   press    out one-cycle pulse, high on the edge at which a 1->0 change of
//                the accepted level takes effect
// ---------------------------------------------------------------------------
module key_debouncer
    import video_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_reg;
    logic          sync2_reg;
    logic          accepted_reg;
    logic [CW-1:0] cnt_reg;
    logic          differs;
    logic          at_limit;

    assign differs  = (sync2_reg != accepted_reg);
    assign at_limit = (cnt_reg == CW'(DEBOUNCE_CYCLES - 1));

    // Combinational so that the top toggles bypass on the same edge the
    // accepted level changes.
    assign press = differs && at_limit && accepted_reg;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            accepted_reg <= 1'b1;
            cnt_reg      <= '0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            if (!differs) begin
                cnt_reg <= '0;
            end else if (at_limit) begin
                accepted_reg <= sync2_reg;
                cnt_reg      <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

endmodule

// File: rtl/video_bypass_ctrl_multi.sv
// ---------------------------------------------------------------------------
// video_bypass_ctrl_multi
// Debounces NUM_CH keys, toggles one bypass bit per channel on each press and
// writes every changed bit to its core over one shared Avalon-MM write master
// with a one-hot chip-select. After reset all channels are written with 0.
//   sys_clk          in  system clock
//   sys_rst          in  asynchronous active-high reset
//   key_n            in  raw active-low keys
//   refresh          in  one-cycle pulse: rewrite all channels
//   bypass           out current bypass state per channel
//   avs_chipselect   out one-hot target core
//   avs_address      out constant CTRL_ADDR
//   avs_write        out write request
//   avs_writedata    out {zeros, bypass bit}
//   avs_waitrequest  in  slave stall
// ---------------------------------------------------------------------------
module video_bypass_ctrl_multi
    import video_ctrl_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADDR_WIDTH      = 1,
    parameter int DATA_WIDTH      = 32,
    parameter int CTRL_ADDR       = 0
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [NUM_CH-1:0]     key_n,
    input  logic                  refresh,
    output logic [NUM_CH-1:0]     bypass,
    output logic [NUM_CH-1:0]     avs_chipselect,
    output logic [ADDR_WIDTH-1:0] avs_address,
    output logic                  avs_write,
    output logic [DATA_WIDTH-1:0] avs_writedata,
    input  logic                  avs_waitrequest
);

    state_t                state_reg;
    logic [NUM_CH-1:0]     bypass_reg;
    logic [NUM_CH-1:0]     pending_reg;
    logic [CH_IDX_W-1:0]   last_reg;
    logic [CH_IDX_W-1:0]   sel_reg;
    logic [CH_IDX_W-1:0]   init_idx_reg;
    logic                  rearm_reg;
    logic [NUM_CH-1:0]     cs_reg;
    logic                  write_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    logic [NUM_CH-1:0]     press_vec;
    logic [NUM_CH-1:0]     set_vec;
    logic [NUM_CH-1:0]     clr_vec;
    logic [MAX_CH-1:0]     pend_ext;
    logic [MAX_CH-1:0]     byp_ext;
    logic [MAX_CH-1:0]     set_ext;
    logic [CH_IDX_W-1:0]   pick;

    // ------------------------------------------------------------------
    // Per-channel key conditioning
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .sys_clk(sys_clk),
                .sys_rst(sys_rst),
                .key_n  (key_n[gi]),
                .press  (press_vec[gi])
            );
        end
    endgenerate

    assign set_vec = press_vec | {NUM_CH{refresh}};

    // Widen to the package's fixed channel range so 4-bit indices and the
    // round-robin helper work for any NUM_CH.
    always_comb begin
        pend_ext               = '0;
        byp_ext                = '0;
        set_ext                = '0;
        pend_ext[NUM_CH-1:0]   = pending_reg;
        byp_ext[NUM_CH-1:0]    = bypass_reg;
        set_ext[NUM_CH-1:0]    = set_vec;
    end

    assign pick = rr_pick(pend_ext, last_reg, NUM_CH);

    // A channel's pending bit is cleared on acceptance only if it was not
    // set again since the write was issued; otherwise the newer state
    // still has to go out. A set on the acceptance edge itself wins too.
    always_comb begin
        clr_vec = '0;
        if (state_reg == S_WRITE && write_reg && !avs_waitrequest && !rearm_reg) begin
            clr_vec = cs_reg;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bypass_reg  <= '0;
            pending_reg <= '0;
        end else begin
            bypass_reg  <= bypass_reg ^ press_vec;
            pending_reg <= (pending_reg & ~clr_vec) | set_vec;
        end
    end

    // ------------------------------------------------------------------
    // Write-master FSM
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg    <= S_INIT;
            init_idx_reg <= '0;
            last_reg     <= CH_IDX_W'(NUM_CH - 1);   // so channel 0 goes first
            sel_reg      <= '0;
            rearm_reg    <= 1'b0;
            cs_reg       <= '0;
            write_reg    <= 1'b0;
            wdata_reg    <= '0;
        end else begin
            case (state_reg)
                S_INIT: begin
                    // Each init write is issued on the edge after the
                    // previous one is accepted, leaving one idle cycle.
                    if (!write_reg) begin
                        cs_reg    <= NUM_CH'(1) << init_idx_reg;
                        write_reg <= 1'b1;
                        wdata_reg <= '0;
                    end else if (!avs_waitrequest) begin
                        write_reg <= 1'b0;
                        cs_reg    <= '0;
                        if (init_idx_reg == CH_IDX_W'(NUM_CH - 1)) begin
                            state_reg <= S_IDLE;
                        end else begin
                            init_idx_reg <= init_idx_reg + CH_IDX_W'(1);
                        end
                    end
                end

                S_IDLE: begin
                    if (|pending_reg) begin
                        sel_reg               <= pick;
                        cs_reg                <= NUM_CH'(1) << pick;
                        write_reg             <= 1'b1;
                        wdata_reg             <= '0;
                        wdata_reg[BYPASS_BIT] <= byp_ext[pick];
                        // A press on this edge toggles bypass after the
                        // data was captured, so it must re-arm the channel.
                        rearm_reg             <= set_ext[pick];
                        state_reg             <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    rearm_reg <= rearm_reg | set_ext[sel_reg];
                    if (!avs_waitrequest) begin
                        write_reg <= 1'b0;
                        cs_reg    <= '0;
                        last_reg  <= sel_reg;
                        state_reg <= S_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_INIT;
                end
            endcase
        end
    end

    assign bypass         = bypass_reg;
    assign avs_chipselect = cs_reg;
    assign avs_write      = write_reg;
    assign avs_writedata  = wdata_reg;
    assign avs_address    = ADDR_WIDTH'(CTRL_ADDR);

endmodule

// File: doc/video_bypass_ctrl_multi.md
# video_bypass_ctrl_multi

Multi-channel successor to the single-key bypass control in the video daisy system. Debounces `NUM_CH` push buttons and toggles one bypass bit per channel on each press. Each changed bit goes to its video core over one shared Avalon-MM write master with a one-hot chip-select. It sits in the `sys_clk` domain between board keys and the per-core control ports (bar, sprite, pacman, rgb2gray, ...). It replaces per-switch wiring with registered, handshaked writes and an initial sync after reset.

## Interface
Parameters:
- `NUM_CH`, 4: number of channels/cores; 1..16
- `DEBOUNCE_CYCLES`, 500000: consecutive stable synchronized cycles before a key change is accepted; ≥2
- `ADDR_WIDTH`, 1: Avalon address width
- `DATA_WIDTH`, 32: Avalon write data width
- `CTRL_ADDR`, 0: address of the bypass register in every core

Ports (one clock; reset is asynchronous and active-high):
- `sys_clk`  in  1  system clock
- `sys_rst`  in  1  asynchronous active-high reset
- `key_n`  in  NUM_CH  raw active-low push buttons, asynchronous to `sys_clk`
- `refresh`  in  1  single-cycle pulse: rewrite every channel's current state
- `bypass`  out  NUM_CH  current bypass state per channel (LED drive)
- `avs_chipselect`  out  NUM_CH  one-hot target core select
- `avs_address`  out  ADDR_WIDTH  always `CTRL_ADDR`
- `avs_write`  out  1  write request
- `avs_writedata`  out  DATA_WIDTH  `{zeros, bypass bit}`
- `avs_waitrequest`  in  1  slave stall; a write is accepted on an edge where `avs_write=1` and `avs_waitrequest=0`

## Operation
- Per channel: 2-FF synchronizer on `key_n[i]`, then a debouncer.
  - Debouncer counter resets to 0 whenever the synchronized value equals the accepted value.
  - Otherwise the counter increments. At `DEBOUNCE_CYCLES-1` the accepted value takes the synchronized value and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles is ignored.
- On an accepted 1→0 transition (press), `bypass[i]` toggles and `pending[i]` sets in the same edge. Release has no effect.
- `refresh` sets all `pending` bits.
- FSM states: INIT, IDLE, WRITE.
  - INIT, entered on reset release: writes 0 to channels 0..N-1 in order, one accepted write each, then goes to IDLE. Presses during INIT set `pending` and are serviced afterwards.
  - IDLE: if any `pending`, select by round-robin starting at the channel after the last one served (channel 0 after reset). Capture `bypass[sel]` into `avs_writedata`, drive `avs_chipselect` one-hot, set `avs_write`, then go to WRITE.
  - WRITE: hold address, data and chipselect stable while `avs_waitrequest=1`. On acceptance, clear `pending[sel]`, drop `avs_write`/`avs_chipselect`, then go to IDLE.
- Simultaneous set and clear of the same `pending` bit: set wins, so the newer state is written again.
- Data is captured at issue; a toggle mid-write never changes `avs_writedata` during a transfer.

## Timing
- Reset values:
  - `bypass=0`, `pending=0`, `avs_write=0`, `avs_chipselect=0`, `avs_writedata=0`, `avs_address=CTRL_ADDR`.
  - Synchronizers and accepted values reset to 1; counters reset to 0; round-robin pointer points so that channel 0 is served first.
- First INIT write is asserted after the first edge following reset deassertion.
- Press latency: `key_n` falls before edge 0 and stays low. `bypass` toggles at edge `DEBOUNCE_CYCLES+1`. `avs_write` is high after edge `DEBOUNCE_CYCLES+2` if the FSM was IDLE.
- Minimum spacing: one idle cycle between consecutive writes. With zero waitrequest, N pending channels complete in 2N cycles.
- Reset mid-write: `avs_write` drops asynchronously, pending writes are discarded, and the INIT sequence restarts.

## Structure
- Package `video_ctrl_pkg`:
  - FSM state enum (`S_INIT`, `S_IDLE`, `S_WRITE`)
  - writedata bypass-bit position constant
  - round-robin pick function (`pending`, `last` → index)
- Sub-module `key_debouncer` (synchronizer + counter + accepted value + press pulse), parametrised by `DEBOUNCE_CYCLES`, instantiated `NUM_CH` times via generate.
- Top holds the `bypass`/`pending` registers, FSM and Avalon outputs.

## Test plan
All scenarios use `NUM_CH=4`, `DEBOUNCE_CYCLES=4`.
- **Reset release, waitrequest=0:** four writes of data 0 to chipselects 0001, 0010, 0100, 1000 on alternate cycles, then idle.
- **Key 2 low 10 cycles:** `bypass=0100` at edge 5; write `0100`/data 1 asserted after edge 6. Second press → data 0.
- **Key 1 low 3 cycles, then high:** no toggle, no write.
- **Keys 0 and 3 accepted same edge:** writes served in round-robin order after the last-served channel. Each write's data is 1.
- **Waitrequest held 5 cycles:** address, data and chipselect stable 5 cycles, accepted on the 6th. A re-press of the same channel during the stall yields a second write with data 0.
- **`refresh` pulse with `bypass=1010`:** four writes carrying 0,1,0,1. Reset asserted mid-write → `avs_write=0` immediately and INIT restarts.
